// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with registered result, flags and error bit.
// Optional iterative multiplier enabled by defining ALU_PIPE_MUL_EN.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (op, a, b)
//   out_valid/out_ready result handshake (c, flags = {n,z,cy,ov}, err)
//   busy                multiplier iterating (always 0 without ALU_PIPE_MUL_EN)
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags,
    output logic             err,
    output logic             busy
);

    localparam int LW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t state, state_nx;

    logic accept;
    logic start_mul;
    logic mul_last;

    // Ready is gated by reset so nothing is handshaken on a reset edge.
    assign in_ready  = !rst &&
                       ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] alu_c;
    logic             alu_cy;
    logic             alu_ov;
    logic             alu_err;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH-1:0] dif;
    logic [WIDTH:0]   shl_x;

    always_comb begin
        alu_c   = '0;
        alu_cy  = 1'b0;
        alu_ov  = 1'b0;
        alu_err = 1'b0;
        sum_x   = {1'b0, a} + {1'b0, b};
        dif     = a - b;
        // Extra top bit catches the last bit shifted out (0 for shift 0).
        shl_x   = {1'b0, a} << b[LW-1:0];
        unique case (op)
            OP_ADD: begin
                alu_c  = sum_x[WIDTH-1:0];
                alu_cy = sum_x[WIDTH];
                alu_ov = (a[WIDTH-1] == b[WIDTH-1]) &&
                         (sum_x[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_c = a & b;
            OP_SUB: begin
                alu_c  = dif;
                alu_cy = (a < b);
                alu_ov = (a[WIDTH-1] != b[WIDTH-1]) &&
                         (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  alu_c = a | b;
            OP_XOR: alu_c = a ^ b;
            OP_SLT: alu_c = {{(WIDTH-1){1'b0}},
                             ($signed(a) < $signed(b))};
            OP_SHL: begin
                alu_c  = shl_x[WIDTH-1:0];
                alu_cy = shl_x[WIDTH];
            end
            OP_MUL: begin
`ifndef ALU_PIPE_MUL_EN
                alu_err = 1'b1;
`endif
            end
            default: alu_c = '0;
        endcase
    end

    // ---------------- multiplier ----------------
`ifdef ALU_PIPE_MUL_EN
    localparam logic [LW-1:0] LAST = LW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [LW-1:0]      cnt;

    assign start_mul = (op == OP_MUL);
    assign busy      = (state == BUSY);
    assign mul_last  = (state == BUSY) && (cnt == LAST);
    assign acc_nx    = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept && start_mul) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == BUSY) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nx;
            cnt    <= cnt + LW'(1);
        end
    end
`else
    assign start_mul = 1'b0;
    assign busy      = 1'b0;
    assign mul_last  = 1'b0;
`endif

    // ---------------- control ----------------
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nx = start_mul ? state_t'(DONE + 0) : DONE;
            end
`ifdef ALU_PIPE_MUL_EN
            BUSY: begin
                if (mul_last) state_nx = DONE;
            end
`endif
            DONE: begin
                if (accept) state_nx = DONE;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
`ifdef ALU_PIPE_MUL_EN
        if (accept && start_mul) state_nx = BUSY;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            c     <= '0;
            flags <= '0;
            err   <= 1'b0;
        end else if (accept && !start_mul) begin
            c     <= alu_c;
            flags <= {alu_c[WIDTH-1], (alu_c == '0), alu_cy, alu_ov};
            err   <= alu_err;
        end
`ifdef ALU_PIPE_MUL_EN
        else if (mul_last) begin
            c     <= acc_nx[WIDTH-1:0];
            flags <= {acc_nx[WIDTH-1], (acc_nx[WIDTH-1:0] == '0),
                      1'b0, (acc_nx[2*WIDTH-1:WIDTH] != '0)};
            err   <= 1'b0;
        end
`endif
    end

endmodule
